// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer and the HI/LO
// source select muxes.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MULT_RUN,
        DIV_RUN,
        WRITE
    } state_e;

    localparam logic DIVCTRL_DIV  = 1'b0;
    localparam logic DIVCTRL_MULT = 1'b1;

    function automatic int max_cycles(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter that times the fixed latency of a multiply or divide.
module lat_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Saturates at zero so a stray dec can never wrap into a long stall.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer that launches the multiplier or divider, waits out its latency and
// then writes HI/LO; divide-by-zero is flagged without launching anything.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = $clog2(max_cycles(MULT_CYCLES, DIV_CYCLES) + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic op_mult,
    input  logic op_div,
    input  logic divisor_zero,
    output logic mult_start,
    output logic div_start,
    output logic div_ctrl,
    output logic hilo_write,
    output logic busy,
    output logic done,
    output logic div_zero_exc
);

    state_e     state_q, state_d;
    logic       mult_start_q, mult_start_d;
    logic       div_start_q, div_start_d;
    logic       div_ctrl_q, div_ctrl_d;
    logic       hilo_write_q, hilo_write_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       div_zero_exc_q, div_zero_exc_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    lat_counter #(
        .W(CNT_W)
    ) u_lat_counter (
        .clk  (clk),
        .reset(reset),
        .load (cnt_load),
        .value(cnt_load_val),
        .dec  (cnt_dec),
        .zero (cnt_zero)
    );

    // Outputs are derived from the next state so every output is a flop.
    always_comb begin
        state_d        = state_q;
        div_ctrl_d     = div_ctrl_q;
        mult_start_d   = 1'b0;
        div_start_d    = 1'b0;
        div_zero_exc_d = 1'b0;
        cnt_load       = 1'b0;
        cnt_load_val   = '0;
        cnt_dec        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (op_mult) begin
                    state_d      = MULT_RUN;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(MULT_CYCLES - 1);
                    mult_start_d = 1'b1;
                    div_ctrl_d   = DIVCTRL_MULT;
                end else if (op_div) begin
                    if (divisor_zero) begin
                        div_zero_exc_d = 1'b1;
                    end else begin
                        state_d      = DIV_RUN;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(DIV_CYCLES - 1);
                        div_start_d  = 1'b1;
                        div_ctrl_d   = DIVCTRL_DIV;
                    end
                end
            end
            MULT_RUN, DIV_RUN: begin
                if (cnt_zero) begin
                    state_d = WRITE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d       = (state_d != IDLE);
        hilo_write_d = (state_d == WRITE);
        done_d       = (state_d == WRITE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            mult_start_q   <= 1'b0;
            div_start_q    <= 1'b0;
            div_ctrl_q     <= DIVCTRL_DIV;
            hilo_write_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            div_zero_exc_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            mult_start_q   <= mult_start_d;
            div_start_q    <= div_start_d;
            div_ctrl_q     <= div_ctrl_d;
            hilo_write_q   <= hilo_write_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            div_zero_exc_q <= div_zero_exc_d;
        end
    end

    assign mult_start   = mult_start_q;
    assign div_start    = div_start_q;
    assign div_ctrl     = div_ctrl_q;
    assign hilo_write   = hilo_write_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign div_zero_exc = div_zero_exc_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: the driver predicts completion events from
// the request timing rules, and a negedge monitor compares what the DUT shows.
module tb_multdiv_ctrl;

    localparam int MULT_N = 4;
    localparam int DIV_N  = 6;

    logic clk = 1'b0;
    logic reset;
    logic op_mult, op_div, divisor_zero;
    logic mult_start, div_start, div_ctrl, hilo_write, busy, done, div_zero_exc;

    multdiv_ctrl #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .op_mult     (op_mult),
        .op_div      (op_div),
        .divisor_zero(divisor_zero),
        .mult_start  (mult_start),
        .div_start   (div_start),
        .div_ctrl    (div_ctrl),
        .hilo_write  (hilo_write),
        .busy        (busy),
        .done        (done),
        .div_zero_exc(div_zero_exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit zexc;
        bit ctrl;
    } exp_t;

    exp_t sb_q[$];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    // Reference model: intervals and event cycles, not states.
    int free_at = 0;
    int busy_lo = 1;
    int busy_hi = 0;
    int mstart_cyc = -1;
    int dstart_cyc = -1;
    bit ctrl_old = 1'b0;
    bit ctrl_new = 1'b0;
    int ctrl_chg = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit exp_ctrl_at(input int c);
        return (c >= ctrl_chg) ? ctrl_new : ctrl_old;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic launch(input int c, input int n, input bit ctrl, input bit is_mult);
        exp_t e;
        ctrl_old = exp_ctrl_at(c);
        ctrl_new = ctrl;
        ctrl_chg = c + 1;
        busy_lo  = c + 1;
        busy_hi  = c + n + 1;
        if (is_mult) mstart_cyc = c + 1;
        else         dstart_cyc = c + 1;
        e.cyc  = c + n + 1;
        e.zexc = 1'b0;
        e.ctrl = ctrl;
        sb_q.push_back(e);
        free_at = c + n + 2;
    endtask

    task automatic applyStimulus(input bit m, input bit d, input bit z, input bit r);
        exp_t e;
        int c;
        c = cyc;
        op_mult      = m;
        op_div       = d;
        divisor_zero = z;
        reset        = r;
        if (!r) begin
            while (sb_q.size() > 0 && sb_q[$].cyc > c) void'(sb_q.pop_back());
            if (busy_hi > c) busy_hi = c;
            if (mstart_cyc > c) mstart_cyc = -1;
            if (dstart_cyc > c) dstart_cyc = -1;
            ctrl_old = exp_ctrl_at(c);
            ctrl_new = 1'b0;
            ctrl_chg = c + 1;
            free_at  = c + 1;
        end else if (c >= free_at) begin
            if (m) begin
                launch(c, MULT_N, 1'b1, 1'b1);
            end else if (d) begin
                if (z) begin
                    e.cyc  = c + 1;
                    e.zexc = 1'b1;
                    e.ctrl = exp_ctrl_at(c);
                    sb_q.push_back(e);
                end else begin
                    launch(c, DIV_N, 1'b0, 1'b0);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: per-cycle level checks plus scoreboard pops on completion events.
    always @(negedge clk) begin
        exp_t e;
        if (cyc >= 1) begin
            checkOutput("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
            checkOutput("mult_start", int'(mult_start), int'(cyc == mstart_cyc));
            checkOutput("div_start", int'(div_start), int'(cyc == dstart_cyc));
            checkOutput("div_ctrl", int'(div_ctrl), int'(exp_ctrl_at(cyc)));
            if (hilo_write || done || div_zero_exc || (sb_q.size() > 0 && sb_q[0].cyc <= cyc)) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_event", int'({hilo_write, done, div_zero_exc}), 0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("event_cycle", cyc, e.cyc);
                    checkOutput("hilo_write", int'(hilo_write), int'(!e.zexc));
                    checkOutput("done", int'(done), int'(!e.zexc));
                    checkOutput("div_zero_exc", int'(div_zero_exc), int'(e.zexc));
                    checkOutput("event_div_ctrl", int'(div_ctrl), int'(e.ctrl));
                end
            end
        end
    end

    initial begin
        // Reset held with a pending multiply request.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        idle(9);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        idle(7);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        idle(3);

        // Contention, ignored divides while running, then back-to-back multiply.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < MULT_N + 1; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        idle(8);

        // Reset three cycles into a divide.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        idle(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        idle(12);

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 49) != 0);
        end
        idle(20);

        checkOutput("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencer for the shared multiply/divide resources feeding the HI/LO registers. It accepts one-cycle operation requests from the main control FSM and launches the multiplier or divider. It counts each unit's fixed latency, then drives the HI/LO source select and a one-cycle write enable. It also raises busy for stalling and flags divide-by-zero without touching HI/LO.

## Interface
- MULT_CYCLES, 32, multiplier latency in cycles (≥1)
- DIV_CYCLES, 32, divider latency in cycles (≥1)
- CNT_W, $clog2(max(MULT_CYCLES,DIV_CYCLES)+1), latency counter width

- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-low
- op_mult  in  1  request multiply; sampled only in IDLE
- op_div  in  1  request divide; sampled only in IDLE
- divisor_zero  in  1  divisor operand is zero; sampled with op_div
- mult_start  out  1  one-cycle launch pulse to multiplier
- div_start  out  1  one-cycle launch pulse to divider
- div_ctrl  out  1  HI/LO source mux select: 0 = divider, 1 = multiplier
- hilo_write  out  1  one-cycle write enable for HI and LO
- busy  out  1  operation in flight; main FSM stalls on it
- done  out  1  one-cycle completion pulse, coincident with hilo_write
- div_zero_exc  out  1  one-cycle divide-by-zero flag

## Operation
- States: IDLE, MULT_RUN, DIV_RUN, WRITE. All outputs registered.
- IDLE with op_mult=1 goes to MULT_RUN. Load cnt=MULT_CYCLES-1, pulse mult_start, set div_ctrl=1.
- IDLE with op_div=1 and divisor_zero=0 goes to DIV_RUN. Load cnt=DIV_CYCLES-1, pulse div_start, set div_ctrl=0.
- IDLE with op_div=1 and divisor_zero=1 stays in IDLE. Pulse div_zero_exc next cycle. No start, no hilo_write, no done, div_ctrl unchanged.
- op_mult and op_div both set in IDLE: multiply wins, divide is dropped.
- MULT_RUN/DIV_RUN: cnt decrements each cycle. When cnt==0, go to WRITE.
- WRITE: hilo_write=1, done=1, then IDLE.
- div_ctrl holds stable from launch through WRITE and keeps its last value in IDLE.
- Requests in any non-IDLE state are ignored, not queued.
- reset=0 on any edge forces IDLE mid-operation. The in-flight result is discarded: no hilo_write.
- Reset values: state IDLE, cnt 0, mult_start 0, div_start 0, div_ctrl 0, hilo_write 0, busy 0, done 0, div_zero_exc 0.

## Timing
- Request sampled at edge T: state changes and the start pulse is high in cycle T+1.
- RUN occupies cycles T+1 .. T+N, where N = MULT_CYCLES or DIV_CYCLES.
- WRITE (hilo_write, done) is in cycle T+N+1. IDLE returns in T+N+2, where a new request is accepted.
- busy is high from T+1 through T+N+1 inclusive and low in IDLE.
- Divide-by-zero: div_zero_exc high in T+1 only, busy stays 0.
- Back-to-back: a request in cycle T+N+2 launches at T+N+3, so there is no gap cycle beyond WRITE.

## Structure
- Package multdiv_pkg holds:
  - state enum (IDLE, MULT_RUN, DIV_RUN, WRITE)
  - DIVCTRL_DIV=1'b0, DIVCTRL_MULT=1'b1, shared with the HI/LO select muxes
- Single FSM module. The loadable down-counter can be factored into sub-module lat_counter (load, value, dec, zero).

## Test plan
- Reset: hold reset=0 for 2 cycles with op_mult=1. All outputs 0, no mult_start; after release, IDLE.
- Multiply (MULT_CYCLES=4): op_mult at T. mult_start at T+1, busy T+1..T+5, hilo_write/done at T+5 with div_ctrl=1, busy=0 at T+6.
- Divide (DIV_CYCLES=6): op_div at T, divisor_zero=0. div_start at T+1, hilo_write at T+7 with div_ctrl=0.
- Divide by zero: op_div=1, divisor_zero=1. div_zero_exc at T+1 only; no div_start, hilo_write or busy; div_ctrl unchanged.
- Contention: op_mult and op_div both high → multiply only. op_div pulses during MULT_RUN are ignored; a second op_mult at T+6 launches at T+7.
- Reset mid-operation: reset=0 at T+3 of a divide. Next cycle IDLE, busy 0, and no hilo_write ever appears for that divide.
